// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for the convolution window path
// Purpose : default geometry constants and the IDLE/RUN/DONE state encoding
//           used by window_coord_gen and coord_bounds.
// Ports   : none (package).
package conv_pkg;

  localparam int COORD_WIDTH_DEF = 8;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int PAD_DEF         = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wcg_state_e;

endpackage

// File: rtl/coord_bounds.sv
// rtl/coord_bounds.sv - tells whether a signed tap coordinate lies inside the image
// Purpose : bounds test shared by window generation and padding_check consumers.
// Ports   : i_row, i_col       signed tap coordinate
//           i_height, i_width  unsigned image dimensions
//           o_in_bounds        1 when 0 <= row < height and 0 <= col < width
module coord_bounds
  import conv_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
  input  logic signed [COORD_WIDTH-1:0] i_row,
  input  logic signed [COORD_WIDTH-1:0] i_col,
  input  logic        [COORD_WIDTH-1:0] i_height,
  input  logic        [COORD_WIDTH-1:0] i_width,
  output logic                          o_in_bounds
);

  logic [COORD_WIDTH-1:0] w_row_u;
  logic [COORD_WIDTH-1:0] w_col_u;

  assign w_row_u = $unsigned(i_row);
  assign w_col_u = $unsigned(i_col);

  // A clear sign bit makes the unsigned view equal to the value, so the
  // upper-bound tests can be done as plain unsigned compares.
  assign o_in_bounds = !i_row[COORD_WIDTH-1] && !i_col[COORD_WIDTH-1] &&
                       (w_row_u < i_height) && (w_col_u < i_width);

endmodule

// File: rtl/window_coord_gen.sv
// rtl/window_coord_gen.sv - scans K x K kernel tap coordinates over a zero-padded frame
// Purpose : emits one tap per handshake in kx, ky, ox, oy order for a "same"
//           stride-1 convolution, with bounds flag and optional linear address.
// Option  : WCG_ADDR_EN - when defined, mem_addr = row*W+col for in-bounds taps;
//           otherwise mem_addr is tied to 0.
// Ports   : clk, rst_n (sync, active-low), start, img_width, img_height, out_ready
//           coord_valid, row_coord, col_coord, in_bounds, mem_addr, tap_idx,
//           last_tap, last_window, busy, done
module window_coord_gen
  import conv_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int PAD         = PAD_DEF,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic        [COORD_WIDTH-1:0] img_width,
  input  logic        [COORD_WIDTH-1:0] img_height,
  input  logic                          out_ready,
  output logic                          coord_valid,
  output logic signed [COORD_WIDTH-1:0] row_coord,
  output logic signed [COORD_WIDTH-1:0] col_coord,
  output logic                          in_bounds,
  output logic        [ADDR_WIDTH-1:0]  mem_addr,
  output logic        [7:0]             tap_idx,
  output logic                          last_tap,
  output logic                          last_window,
  output logic                          busy,
  output logic                          done
);

  // Largest dimension whose padded coordinates still fit the signed range.
  localparam logic [COORD_WIDTH-1:0] MAX_DIM = COORD_WIDTH'((1 << (COORD_WIDTH - 1)) - 1 - PAD);
  localparam logic [COORD_WIDTH-1:0] ONE     = COORD_WIDTH'(1);
  localparam logic [COORD_WIDTH-1:0] PAD_C   = COORD_WIDTH'(PAD);
  localparam logic [7:0]             K_LAST  = 8'(KERNEL_SIZE - 1);
  localparam logic [7:0]             K_8     = 8'(KERNEL_SIZE);

  wcg_state_e r_state, w_state_n;
  logic [COORD_WIDTH-1:0] r_w, r_h, r_oy, r_ox;
  logic [COORD_WIDTH-1:0] w_w_n, w_h_n, w_oy_n, w_ox_n;
  logic [7:0]             r_ky, r_kx, w_ky_n, w_kx_n;
  logic                   w_load, w_done_n;

  logic                          r_valid, r_inb, r_last_tap, r_last_win, r_busy, r_done;
  logic signed [COORD_WIDTH-1:0] r_row, r_col;
  logic [7:0]                    r_tap;

  logic signed [COORD_WIDTH-1:0] w_row_n, w_col_n;
  logic                          w_inb_n, w_lt_n, w_lw_n;
  logic [7:0]                    w_tap_n;

  always_comb begin
    w_state_n = r_state;
    w_w_n     = r_w;
    w_h_n     = r_h;
    w_oy_n    = r_oy;
    w_ox_n    = r_ox;
    w_ky_n    = r_ky;
    w_kx_n    = r_kx;
    w_load    = 1'b0;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_w_n  = (img_width  > MAX_DIM) ? MAX_DIM : img_width;
          w_h_n  = (img_height > MAX_DIM) ? MAX_DIM : img_height;
          w_oy_n = '0;
          w_ox_n = '0;
          w_ky_n = '0;
          w_kx_n = '0;
          if ((w_w_n == '0) || (w_h_n == '0)) begin
            w_state_n = DONE;
          end else begin
            w_state_n = RUN;
            w_load    = 1'b1;
          end
        end
      end
      RUN: begin
        // coord_valid is always high in RUN, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (r_last_tap && r_last_win) begin
            w_state_n = DONE;
          end else begin
            w_load = 1'b1;
            if (r_kx == K_LAST) begin
              w_kx_n = '0;
              if (r_ky == K_LAST) begin
                w_ky_n = '0;
                if (r_ox == r_w - ONE) begin
                  w_ox_n = '0;
                  w_oy_n = r_oy + ONE;
                end else begin
                  w_ox_n = r_ox + ONE;
                end
              end else begin
                w_ky_n = r_ky + 8'd1;
              end
            end else begin
              w_kx_n = r_kx + 8'd1;
            end
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
        w_done_n  = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Tap outputs are derived from the next counter values so they can be
  // registered on the same edge that advances the scan.
  assign w_row_n = w_oy_n + COORD_WIDTH'(w_ky_n) - PAD_C;
  assign w_col_n = w_ox_n + COORD_WIDTH'(w_kx_n) - PAD_C;
  assign w_tap_n = w_ky_n * K_8 + w_kx_n;
  assign w_lt_n  = (w_ky_n == K_LAST) && (w_kx_n == K_LAST);
  assign w_lw_n  = (w_oy_n == w_h_n - ONE) && (w_ox_n == w_w_n - ONE);

  coord_bounds #(
    .COORD_WIDTH (COORD_WIDTH)
  ) u_bounds (
    .i_row       (w_row_n),
    .i_col       (w_col_n),
    .i_height    (w_h_n),
    .i_width     (w_w_n),
    .o_in_bounds (w_inb_n)
  );

`ifdef WCG_ADDR_EN
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_n;
  assign w_addr_n = w_inb_n ? (ADDR_WIDTH'($unsigned(w_row_n)) * ADDR_WIDTH'(w_w_n) +
                               ADDR_WIDTH'($unsigned(w_col_n))) : '0;
  assign mem_addr = r_addr;
`else
  assign mem_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_w        <= '0;
      r_h        <= '0;
      r_oy       <= '0;
      r_ox       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_valid    <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_inb      <= 1'b0;
      r_tap      <= '0;
      r_last_tap <= 1'b0;
      r_last_win <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef WCG_ADDR_EN
      r_addr     <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_w     <= w_w_n;
      r_h     <= w_h_n;
      r_oy    <= w_oy_n;
      r_ox    <= w_ox_n;
      r_ky    <= w_ky_n;
      r_kx    <= w_kx_n;
      r_busy  <= (w_state_n == RUN);
      r_done  <= w_done_n;
      if (w_state_n != RUN) begin
        r_valid    <= 1'b0;
        r_row      <= '0;
        r_col      <= '0;
        r_inb      <= 1'b0;
        r_tap      <= '0;
        r_last_tap <= 1'b0;
        r_last_win <= 1'b0;
`ifdef WCG_ADDR_EN
        r_addr     <= '0;
`endif
      end else if (w_load) begin
        r_valid    <= 1'b1;
        r_row      <= w_row_n;
        r_col      <= w_col_n;
        r_inb      <= w_inb_n;
        r_tap      <= w_tap_n;
        r_last_tap <= w_lt_n;
        r_last_win <= w_lw_n;
`ifdef WCG_ADDR_EN
        r_addr     <= w_addr_n;
`endif
      end
    end
  end

  assign coord_valid = r_valid;
  assign row_coord   = r_row;
  assign col_coord   = r_col;
  assign in_bounds   = r_inb;
  assign tap_idx     = r_tap;
  assign last_tap    = r_last_tap;
  assign last_window = r_last_win;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_window_coord_gen.sv
// tb/tb_window_coord_gen.sv - self-checking bench for window_coord_gen
module tb_window_coord_gen;

  localparam int K    = 3;
  localparam int PADW = 1;
  localparam int MAXD = 126;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic [7:0]  img_width, img_height;
  logic        coord_valid, in_bounds, last_tap, last_window, busy, done;
  logic signed [7:0] row_coord, col_coord;
  logic [15:0] mem_addr;
  logic [7:0]  tap_idx;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];

  window_coord_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .img_width   (img_width),
    .img_height  (img_height),
    .out_ready   (out_ready),
    .coord_valid (coord_valid),
    .row_coord   (row_coord),
    .col_coord   (col_coord),
    .in_bounds   (in_bounds),
    .mem_addr    (mem_addr),
    .tap_idx     (tap_idx),
    .last_tap    (last_tap),
    .last_window (last_window),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] obs();
    return {18'd0, busy, done, coord_valid, row_coord, col_coord, in_bounds,
            mem_addr, tap_idx, last_tap, last_window};
  endfunction

  function automatic logic [63:0] pack(input logic b, input logic d, input logic v,
                                        input int row, input int col, input int inb,
                                        input int addr, input int tap, input int lt,
                                        input int lw);
    logic [7:0]  r8, c8, t8;
    logic [15:0] a16;
    r8  = row[7:0];
    c8  = col[7:0];
    t8  = tap[7:0];
    a16 = addr[15:0];
    return {18'd0, b, d, v, r8, c8, inb[0], a16, t8, lt[0], lw[0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: every tap of a frame, in scan order, straight from the geometry.
  task automatic build(input int w, input int h);
    int wc, hc, row, col, inb, addr;
    wc = (w > MAXD) ? MAXD : w;
    hc = (h > MAXD) ? MAXD : h;
    q.delete();
    for (int oy = 0; oy < hc; oy++)
      for (int ox = 0; ox < wc; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            row  = oy + ky - PADW;
            col  = ox + kx - PADW;
            inb  = (row >= 0 && row < hc && col >= 0 && col < wc) ? 1 : 0;
            addr = 0;
`ifdef WCG_ADDR_EN
            if (inb != 0) addr = row * wc + col;
`endif
            q.push_back(pack(1'b1, 1'b0, 1'b1, row, col, inb, addr, ky * K + kx,
                             (ky == K - 1 && kx == K - 1) ? 1 : 0,
                             (oy == hc - 1 && ox == wc - 1) ? 1 : 0));
          end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready 1,0,0,1 then high
  task automatic run_frame(input int w, input int h, input int mode);
    int cyc, bound;
    build(w, h);
    bound = q.size() * 10 + 50;
    img_width  = w[7:0];
    img_height = h[7:0];
    start      = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
    while (q.size() > 0 && cyc < bound) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      endcase
      chk("tap", obs(), q[0]);
      if (out_ready) void'(q.pop_front());
      cyc++;
      step();
    end
    chk("frame_complete", 64'(q.size()), 64'd0);
    chk("after_last", obs(), 64'd0);
    step();
    chk("done_pulse", obs(), pack(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("back_idle", obs(), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    img_width  = '0;
    img_height = '0;
    step();
    step();
    chk("reset_state", obs(), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_state", obs(), 64'd0);

    run_frame(5, 5, 0);
    run_frame(5, 5, 2);
    for (int n = 0; n < 3; n++)
      run_frame(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), 1);
    run_frame(0, 4, 0);
    run_frame(3, 0, 0);
    run_frame(130, 1, 0);
    run_frame(1, 2, 1);

    // Start must be ignored while a frame is running.
    build(2, 2);
    img_width  = 8'd2;
    img_height = 8'd2;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    img_width  = 8'd7;
    img_height = 8'd7;
    for (int c = 0; c < 36; c++) begin
      chk("start_ignored", obs(), q[c]);
      step();
    end
    start = 1'b0;
    chk("ign_end", obs(), 64'd0);
    step();
    chk("ign_done", done, 1'b1);
    step();

    // Abort mid-frame with reset, then rescan from the first tap.
    build(5, 5);
    img_width  = 8'd5;
    img_height = 8'd5;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      void'(q.pop_front());
      step();
    end
    chk("tap40", obs(), q[0]);
    rst_n = 1'b0;
    step();
    chk("reset_mid_frame", obs(), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("no_done_after_abort", obs(), 64'd0);
    end
    run_frame(5, 5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
